// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct encodings and default widths for the pipeline.
package mips_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_SLL = 6'd0;
    localparam logic [5:0] F_SRL = 6'd2;
    localparam logic [5:0] F_SRA = 6'd3;

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection for the instruction sitting in IF/ID.
module hazard_detect_unit
    import mips_pkg::*;
(
    input  logic [31:0] ifid_instr,
    input  logic        ifid_valid,
    input  logic        idex_memRead,
    input  logic [4:0]  idex_rt,
    output logic        hazardFlag,
    output logic        uses_rs,
    output logic        uses_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;

    assign opcode = ifid_instr[31:26];
    assign funct  = ifid_instr[5:0];
    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];

    // Source-register usage and the stall decision against a load in EX.
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        hazardFlag = 1'b0;
        if (ifid_valid) begin
            uses_rs = !is_jump(opcode) &&
                      !((opcode == OP_RTYPE) &&
                        ((funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA)));
            uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                      (opcode == OP_BNE)   || (opcode == OP_SW);
        end
        hazardFlag = idex_memRead && (idex_rt != 5'd0) &&
                     ((uses_rs && (idex_rt == rs)) || (uses_rt && (idex_rt == rt)));
    end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall, jump redirect, flush and
// a saturating stall counter.
module if_id_hazard_stage
    import mips_pkg::*;
#(
    parameter int unsigned PC_W    = mips_pkg::PC_W,
    parameter int unsigned INSTR_W = mips_pkg::INSTR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic [PC_W-1:0]    PC,
    input  logic               branchFlag,
    input  logic               idex_memRead,
    input  logic [4:0]         idex_rt,
    output logic               hazardFlag,
    output logic [5:0]         opcjump,
    output logic [PC_W-1:0]    jumpPC,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [31:0]        imm_sext,
    output logic               bubble,
    output logic [CNT_W-1:0]   stall_count
);

    logic [5:0] opcode;
    logic       jump_in_id;
    logic       uses_rs;
    logic       uses_rt;

    hazard_detect_unit u_hazard (
        .ifid_instr   (ifid_instr[31:0]),
        .ifid_valid   (ifid_valid),
        .idex_memRead (idex_memRead),
        .idex_rt      (idex_rt),
        .hazardFlag   (hazardFlag),
        .uses_rs      (uses_rs),
        .uses_rt      (uses_rt)
    );

    assign opcode   = ifid_instr[31:26];
    assign rs       = ifid_instr[25:21];
    assign rt       = ifid_instr[20:16];
    assign rd       = ifid_instr[15:11];
    assign shamt    = ifid_instr[10:6];
    assign funct    = ifid_instr[5:0];
    assign imm_sext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    assign jumpPC   = ifid_instr[PC_W-1:0];

    // Jump decode toward fetch and the zero-control request toward ID/EX.
    always_comb begin
        jump_in_id = ifid_valid && is_jump(opcode);
        opcjump    = ifid_valid ? opcode : 6'd0;
        bubble     = !ifid_valid || hazardFlag || branchFlag;
    end

    // IF/ID register: flush beats stall, stall beats jump squash, else load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (branchFlag) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (hazardFlag) begin
            ifid_instr <= ifid_instr;
            ifid_pc    <= ifid_pc;
            ifid_valid <= ifid_valid;
        end else if (jump_in_id) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else begin
            ifid_instr <= Instruction;
            ifid_pc    <= PC;
            ifid_valid <= 1'b1;
        end
    end

    // Saturating count of edges spent stalled (a flush does not count).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (hazardFlag && !branchFlag && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor checks.
module tb_if_id_hazard_stage;

    localparam int PW = 10;

    logic          clk;
    logic          reset;
    logic [31:0]   Instruction;
    logic [PW-1:0] PC;
    logic          branchFlag;
    logic          idex_memRead;
    logic [4:0]    idex_rt;
    logic          hazardFlag;
    logic [5:0]    opcjump;
    logic [PW-1:0] jumpPC;
    logic [31:0]   ifid_instr;
    logic [PW-1:0] ifid_pc;
    logic          ifid_valid;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [31:0]   imm_sext;
    logic          bubble;
    logic [15:0]   stall_count;

    if_id_hazard_stage #(.PC_W(PW), .INSTR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .PC(PC),
        .branchFlag(branchFlag), .idex_memRead(idex_memRead), .idex_rt(idex_rt),
        .hazardFlag(hazardFlag), .opcjump(opcjump), .jumpPC(jumpPC),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_sext(imm_sext), .bubble(bubble), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          haz;
        logic [5:0]    opj;
        logic [PW-1:0] jpc;
        logic [31:0]   instr;
        logic [PW-1:0] pc;
        logic          valid;
        logic [4:0]    rs, rt, rd, sh;
        logic [5:0]    fn;
        logic [31:0]   imm;
        logic          bub;
        logic [15:0]   cnt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference state of the stage as seen by the program.
    logic [31:0]   m_instr;
    logic [PW-1:0] m_pc;
    logic          m_valid;
    int            m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hazardFlag", 32'(hazardFlag), 32'(e.haz));
            chk("opcjump", 32'(opcjump), 32'(e.opj));
            chk("jumpPC", 32'(jumpPC), 32'(e.jpc));
            chk("ifid_instr", ifid_instr, e.instr);
            chk("ifid_pc", 32'(ifid_pc), 32'(e.pc));
            chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
            chk("rs", 32'(rs), 32'(e.rs));
            chk("rt", 32'(rt), 32'(e.rt));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("shamt", 32'(shamt), 32'(e.sh));
            chk("funct", 32'(funct), 32'(e.fn));
            chk("imm_sext", imm_sext, e.imm);
            chk("bubble", 32'(bubble), 32'(e.bub));
            chk("stall_count", 32'(stall_count), 32'(e.cnt));
        end
    end

    // Does the live instruction read a given register slot?
    function automatic bit reads_rs(input logic [31:0] ins, input logic v);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (!v) return 0;
        if (op == 2 || op == 3) return 0;
        if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) return 0;
        return 1;
    endfunction

    function automatic bit reads_rt(input logic [31:0] ins, input logic v);
        int op = int'(ins[31:26]);
        return v && (op == 0 || op == 4 || op == 5 || op == 43);
    endfunction

    function automatic bit model_haz(input logic mr, input logic [4:0] drt);
        if (!mr || drt == 0) return 0;
        return (reads_rs(m_instr, m_valid) && drt == m_instr[25:21]) ||
               (reads_rt(m_instr, m_valid) && drt == m_instr[20:16]);
    endfunction

    // Drive one cycle (called at posedge+1), predict outputs, then advance model.
    task automatic step(input logic rst, input logic [31:0] ins, input logic [PW-1:0] p,
                        input logic br, input logic mr, input logic [4:0] drt);
        exp_t e;
        bit h;
        int op;
        reset = rst; Instruction = ins; PC = p;
        branchFlag = br; idex_memRead = mr; idex_rt = drt;
        if (!rst) begin
            m_instr = 0; m_pc = 0; m_valid = 0; m_cnt = 0;
        end
        h  = model_haz(mr, drt);
        op = int'(m_instr[31:26]);
        e.haz   = h;
        e.opj   = m_valid ? 6'(op) : 6'd0;
        e.jpc   = PW'(m_instr % (1 << PW));
        e.instr = m_instr;
        e.pc    = m_pc;
        e.valid = m_valid;
        e.rs    = 5'((m_instr >> 21) & 31);
        e.rt    = 5'((m_instr >> 16) & 31);
        e.rd    = 5'((m_instr >> 11) & 31);
        e.sh    = 5'((m_instr >> 6) & 31);
        e.fn    = 6'(m_instr & 63);
        e.imm   = m_instr[15] ? (32'hFFFF0000 | (m_instr & 32'hFFFF)) : (m_instr & 32'hFFFF);
        e.bub   = !m_valid || h || br;
        e.cnt   = 16'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (h && !br && m_cnt < 65535) m_cnt++;
            if (br) begin
                m_instr = 0; m_pc = 0; m_valid = 0;
            end else if (h) begin
                // hold
            end else if (m_valid && (op == 2 || op == 3)) begin
                m_instr = 0; m_valid = 0;
            end else begin
                m_instr = ins; m_pc = p; m_valid = 1;
            end
        end
        #1;
    endtask

    logic [31:0] pool [8] = '{32'h00851820, 32'h00A43022, 32'h8C220004, 32'hAC430008,
                              32'h10430005, 32'h08000123, 32'h0C000045, 32'h00021080};

    initial begin
        logic [31:0] ins;
        int wait_cnt;
        reset = 1'b0; Instruction = 32'h8C220004; PC = 1;
        branchFlag = 0; idex_memRead = 0; idex_rt = 0;
        m_instr = 0; m_pc = 0; m_valid = 0; m_cnt = 0;
        @(posedge clk); #1;

        // Reset held two cycles, then release with a load presented.
        step(0, 32'h8C220004, 1, 0, 0, 0);
        step(0, 32'h8C220004, 1, 0, 0, 0);
        step(1, 32'h8C220004, 1, 0, 0, 0);
        // add then sub, no load in EX.
        step(1, 32'h00851820, 2, 0, 0, 0);
        step(1, 32'h00A43022, 3, 0, 0, 0);
        step(1, 32'h00432020, 4, 0, 0, 0);
        // add $4,$2,$3 in ID vs load of $2: one-cycle stall, then load gone.
        step(1, 32'h00000000, 5, 0, 1, 2);
        step(1, 32'h00000000, 5, 0, 0, 0);
        // Same pattern with idex_rt=0 must not stall.
        step(1, 32'h00432020, 6, 0, 0, 0);
        step(1, 32'h00000000, 7, 0, 1, 0);
        // Jump in ID squashes the sequential slot.
        step(1, 32'h08000123, 8, 0, 0, 0);
        step(1, 32'h00851820, 9, 0, 0, 0);
        step(1, 32'h00A43022, 10'h123, 0, 0, 0);
        // Flush concurrent with stall.
        step(1, 32'h00432020, 11, 0, 0, 0);
        step(1, 32'h00851820, 12, 1, 1, 2);
        step(1, 32'h00A43022, 13, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            ins = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                ins[25:21] = 5'($urandom_range(0, 3));
                ins[20:16] = 5'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) ins = $urandom;
            step(1, ins, PW'($urandom), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        // Long stall to saturate the counter, then reset mid-stall.
        step(1, 32'h00432020, 20, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(1, 32'h00851820, 21, 0, 1, 2);
        step(0, 32'h00851820, 21, 0, 1, 2);
        step(1, 32'h00851820, 22, 0, 0, 0);
        step(1, 32'h00A43022, 23, 0, 0, 0);

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk); wait_cnt++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
